mdu_iterative: RTL and testbench

//  Parametrised iterative multiply/divide unit with its own HI/LO register pair.

---
 rtl/mdu_iterative.sv | 203 ++++++++++++++++++++
 tb/tb_mdu_iterative.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// mdu_iterative: iterative multiply/divide unit owning the HI/LO register pair.
// Runs MULT/MULTU, MADD/MADDU, MSUB/MSUBU and DIV/DIVU one bit per cycle on a
// shared 2*DATA_W accumulator. MTHI/MTLO write HI/LO directly from IDLE.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start_i, op_i             request and op code (sampled only in IDLE)
//   operand_1_i, operand_2_i  multiplicand/dividend/MT source, multiplier/divisor
//   cancel_i                  abort the in-flight op, no HI/LO write
//   busy_o, done_o            stall request, one-cycle completion pulse
//   result_hi_o, result_lo_o  new HI/LO (remainder/quotient for divide), valid with done_o
//   div_by_zero_o             divide with zero divisor, valid with done_o
//   hi_o, lo_o                architectural HI/LO contents
module mdu_iterative #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] operand_1_i,
  input  logic [DATA_W-1:0] operand_2_i,
  input  logic              cancel_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_hi_o,
  output logic [DATA_W-1:0] result_lo_o,
  output logic              div_by_zero_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  localparam int unsigned      PW   = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_e;
  state_e state_q, state_d;

  logic [2:0]        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;   // multiplicand or divisor magnitude
  logic [PW-1:0]     acc_q, acc_d;       // {prod_hi, prod_lo} or {remainder, quotient}
  logic              neg_lo_q, neg_lo_d; // negate product / quotient
  logic              neg_hi_q, neg_hi_d; // negate remainder
  logic              dbz_q, dbz_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

  // Request decode and operand magnitudes
  logic              signed_op, a_neg, b_neg, is_div_in, div0_in, launch, mt_write;
  logic [DATA_W-1:0] mag_a, mag_b;
  always_comb begin
    signed_op = ~op_i[0];
    a_neg     = signed_op & operand_1_i[DATA_W-1];
    b_neg     = signed_op & operand_2_i[DATA_W-1];
    mag_a     = a_neg ? (~operand_1_i + DATA_W'(1)) : operand_1_i;
    mag_b     = b_neg ? (~operand_2_i + DATA_W'(1)) : operand_2_i;
    is_div_in = (op_i[3:1] == 3'b011);
    div0_in   = is_div_in & (operand_2_i == '0);
    launch    = (state_q == S_IDLE) & start_i & ~cancel_i & ~op_i[3];
    mt_write  = (state_q == S_IDLE) & start_i & ~cancel_i & (op_i[3:1] == 3'b100);
  end

  // Sign fix and HI/LO accumulation, applied in FINISH
  logic [PW-1:0]     prod_s, hilo, mul_res;
  logic [DATA_W-1:0] quo_s, rem_s, fin_hi, fin_lo;
  always_comb begin
    prod_s = neg_lo_q ? (~acc_q + PW'(1)) : acc_q;
    hilo   = {hi_q, lo_q};
    quo_s  = neg_lo_q ? (~acc_q[DATA_W-1:0] + DATA_W'(1)) : acc_q[DATA_W-1:0];
    rem_s  = neg_hi_q ? (~acc_q[PW-1:DATA_W] + DATA_W'(1)) : acc_q[PW-1:DATA_W];
    case (op_q[2:1])
      2'b01:   mul_res = hilo + prod_s;
      2'b10:   mul_res = hilo - prod_s;
      default: mul_res = prod_s;
    endcase
    if (op_q[2:1] == 2'b11) begin
      fin_hi = rem_s;
      fin_lo = quo_s;
    end else begin
      fin_hi = mul_res[PW-1:DATA_W];
      fin_lo = mul_res[DATA_W-1:0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state; a zero divisor bypasses CALC
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (launch) state_d = div0_in ? S_FINISH : S_CALC;
      S_CALC: begin
        if (cancel_i)           state_d = S_IDLE;
        else if (cnt_q == LAST) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy_o        = (state_q != S_IDLE);
    done_o        = (state_q == S_FINISH);
    div_by_zero_o = (state_q == S_FINISH) & dbz_q;
    result_hi_o   = (state_q == S_FINISH) ? fin_hi : '0;
    result_lo_o   = (state_q == S_FINISH) ? fin_lo : '0;
  end

  // Datapath next state: one shift-add or restoring-divide step per CALC cycle
  logic [DATA_W:0] mul_sum, div_trial;
  always_comb begin
    op_d     = op_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mul_sum   = {1'b0, acc_q[PW-1:DATA_W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    div_trial = {acc_q[PW-1:DATA_W], acc_q[DATA_W-1]} - {1'b0, mcand_q};
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          op_d  = op_i[2:0];
          cnt_d = '0;
          dbz_d = div0_in;
          if (div0_in) begin
            // Raw result: HI = dividend, LO = all ones, no sign fix
            acc_d    = {operand_1_i, {DATA_W{1'b1}}};
            neg_lo_d = 1'b0;
            neg_hi_d = 1'b0;
          end else if (is_div_in) begin
            mcand_d  = mag_b;
            acc_d    = {{DATA_W{1'b0}}, mag_a};
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
          end else begin
            mcand_d  = mag_a;
            acc_d    = {{DATA_W{1'b0}}, mag_b};
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = 1'b0;
          end
        end
        if (mt_write) begin
          if (op_i[0]) lo_d = operand_1_i;
          else         hi_d = operand_1_i;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q[2:1] == 2'b11) begin
          // Quotient bit is 1 when the trial subtract does not borrow
          if (!div_trial[DATA_W]) acc_d = {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
          else                    acc_d = {acc_q[PW-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[DATA_W-1:1]};
        end
      end
      S_FINISH: begin
        if (!cancel_i) begin
          hi_d = fin_hi;
          lo_d = fin_lo;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: scoreboard bench for mdu_iterative at DATA_W=32 (u_dut32)
// and DATA_W=8 (u_dut8). Expected results come from a behavioural model.
module tb_mdu_iterative;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        start32, cancel32, busy32, done32, dbz32;
  logic [3:0]  op32;
  logic [31:0] a32, b32, res_hi32, res_lo32, hi32, lo32;
  logic        start8, cancel8, busy8, done8, dbz8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, res_hi8, res_lo8, hi8, lo8;

  mdu_iterative #(.DATA_W(32), .CNT_W(6)) u_dut32 (
    .clk(clk), .rst(rst), .start_i(start32), .op_i(op32),
    .operand_1_i(a32), .operand_2_i(b32), .cancel_i(cancel32),
    .busy_o(busy32), .done_o(done32), .result_hi_o(res_hi32), .result_lo_o(res_lo32),
    .div_by_zero_o(dbz32), .hi_o(hi32), .lo_o(lo32)
  );

  mdu_iterative #(.DATA_W(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .op_i(op8),
    .operand_1_i(a8), .operand_2_i(b8), .cancel_i(cancel8),
    .busy_o(busy8), .done_o(done8), .result_hi_o(res_hi8), .result_lo_o(res_lo8),
    .div_by_zero_o(dbz8), .hi_o(hi8), .lo_o(lo8)
  );

  typedef struct {
    int          sel;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt32 = 0;
  logic [31:0] mhi[2];
  logic [31:0] mlo[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: sel 0 -> 32-bit unit, sel 1 -> 8-bit unit
  function automatic void model(input int w, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] hi,
                                input logic [31:0] lo, output logic [31:0] rhi,
                                output logic [31:0] rlo, output logic rdbz);
    logic [63:0] mask, pmask, ua, ub, p, hl, r;
    longint      sa, sbv, q, rm;
    mask  = (w == 32) ? 64'hFFFF_FFFF : 64'hFF;
    pmask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF;
    ua    = {32'h0, a} & mask;
    ub    = {32'h0, b} & mask;
    sa    = (w == 32) ? longint'($signed(a)) : longint'($signed(a[7:0]));
    sbv   = (w == 32) ? longint'($signed(b)) : longint'($signed(b[7:0]));
    rdbz  = 1'b0;
    if (op[2:1] == 2'b11) begin
      if (ub == 64'h0) begin
        rdbz = 1'b1;
        rlo  = 32'(mask);
        rhi  = 32'(ua);
      end else if (!op[0]) begin
        q   = sa / sbv;
        rm  = sa % sbv;
        rlo = 32'(64'(q) & mask);
        rhi = 32'(64'(rm) & mask);
      end else begin
        rlo = 32'(ua / ub);
        rhi = 32'(ua % ub);
      end
    end else begin
      p  = (!op[0]) ? 64'(sa * sbv) : (ua * ub);
      p  = p & pmask;
      hl = ((({32'h0, hi} & mask) << w) | ({32'h0, lo} & mask));
      case (op[2:1])
        2'b01:   r = hl + p;
        2'b10:   r = hl - p;
        default: r = p;
      endcase
      r   = r & pmask;
      rhi = 32'(r >> w);
      rlo = 32'(r & mask);
    end
  endfunction

  task automatic drive(input int sel, input logic st, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic cn);
    if (sel == 0) begin
      start32 = st; op32 = op; a32 = a; b32 = b; cancel32 = cn;
    end else begin
      start8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0]; cancel8 = cn;
    end
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? done32 : done8;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy32 : busy8;
  endfunction
  function automatic logic [31:0] get_hi(input int sel);
    return (sel == 0) ? hi32 : {24'h0, hi8};
  endfunction
  function automatic logic [31:0] get_lo(input int sel);
    return (sel == 0) ? lo32 : {24'h0, lo8};
  endfunction

  task automatic sb_pop(input int sel, input logic [31:0] rh, input logic [31:0] rl,
                        input logic dz);
    exp_t e;
    check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("sb_sel", 64'(sel), 64'(e.sel));
      check("result_hi", 64'(rh), 64'(e.hi));
      check("result_lo", 64'(rl), 64'(e.lo));
      check("div_by_zero", 64'(dz), 64'(e.dbz));
    end
  endtask

  // Output monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (done32) begin
      done_cnt32++;
      sb_pop(0, res_hi32, res_lo32, dbz32);
    end
    if (done8) sb_pop(1, {24'h0, res_hi8}, {24'h0, res_lo8}, dbz8);
  end

  // Launch one op, wait for done (cycle 1 = cycle after the start edge), check HI/LO
  task automatic run_op(input int sel, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    logic [31:0] rh, rl;
    logic        dz;
    exp_t        e;
    int          n;
    model((sel == 0) ? 32 : 8, op, a, b, mhi[sel], mlo[sel], rh, rl, dz);
    @(negedge clk);
    drive(sel, 1'b1, op, a, b, 1'b0);
    e.sel = sel; e.hi = rh; e.lo = rl; e.dbz = dz;
    sb_q.push_back(e);
    @(negedge clk);
    drive(sel, 1'b0, op, $urandom, $urandom, 1'b0);
    n = 1;
    while (!get_done(sel) && n < 100) begin
      @(negedge clk);
      n++;
    end
    lat = get_done(sel) ? n : -1;
    @(negedge clk);
    mhi[sel] = rh;
    mlo[sel] = rl;
    check("arch_hi", 64'(get_hi(sel)), 64'(mhi[sel]));
    check("arch_lo", 64'(get_lo(sel)), 64'(mlo[sel]));
    check("idle_after_op", 64'(get_busy(sel)), 64'd0);
  endtask

  // MTHI (8) / MTLO (9), optionally with cancel_i asserted in the same cycle
  task automatic mt(input int sel, input logic [3:0] op, input logic [31:0] v, input logic cn);
    logic [31:0] m;
    m = (sel == 0) ? 32'hFFFF_FFFF : 32'hFF;
    @(negedge clk);
    drive(sel, 1'b1, op, v, 32'h0, cn);
    @(negedge clk);
    check("mt_busy", 64'(get_busy(sel)), 64'd0);
    check("mt_done", 64'(get_done(sel)), 64'd0);
    drive(sel, 1'b0, 4'd15, 32'h0, 32'h0, 1'b0);
    if (!cn) begin
      if (op == 4'd8) mhi[sel] = v & m;
      else            mlo[sel] = v & m;
    end
    check("mt_hi", 64'(get_hi(sel)), 64'(mhi[sel]));
    check("mt_lo", 64'(get_lo(sel)), 64'(mlo[sel]));
  endtask

  // MULT on the 32-bit unit with cancel_i high during cycle 'at'
  task automatic run_cancel(input int at, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] rh, rl;
    logic        dz;
    exp_t        e;
    int          dn0;
    model(32, 4'd0, a, b, mhi[0], mlo[0], rh, rl, dz);
    @(negedge clk);
    drive(0, 1'b1, 4'd0, a, b, 1'b0);
    if (at == 33) begin
      e.sel = 0; e.hi = rh; e.lo = rl; e.dbz = dz;
      sb_q.push_back(e);
    end
    dn0 = done_cnt32;
    @(negedge clk);
    drive(0, 1'b0, 4'd0, a, b, 1'b0);
    repeat (at - 1) @(negedge clk);
    check("busy_before_cancel", 64'(busy32), 64'd1);
    cancel32 = 1'b1;
    @(negedge clk);
    cancel32 = 1'b0;
    check("cancel_busy", 64'(busy32), 64'd0);
    check("cancel_done_count", 64'(done_cnt32 - dn0), (at == 33) ? 64'd1 : 64'd0);
    check("cancel_hi", 64'(hi32), 64'(mhi[0]));
    check("cancel_lo", 64'(lo32), 64'(mlo[0]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'({busy32, busy8}), 64'd0);
    check({tag, "_done"}, 64'({done32, done8}), 64'd0);
    check({tag, "_dbz"}, 64'({dbz32, dbz8}), 64'd0);
    check({tag, "_res32"}, {res_hi32, res_lo32}, 64'd0);
    check({tag, "_res8"}, 64'({res_hi8, res_lo8}), 64'd0);
    check({tag, "_hilo32"}, {hi32, lo32}, 64'd0);
    check({tag, "_hilo8"}, 64'({hi8, lo8}), 64'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    drive(0, 1'b0, 4'd15, 32'h0, 32'h0, 1'b0);
    drive(1, 1'b0, 4'd15, 32'h0, 32'h0, 1'b0);
    mhi[0] = '0; mlo[0] = '0; mhi[1] = '0; mlo[1] = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Directed vectors on the 32-bit unit
    run_op(0, 4'd0, 32'hFFFF_FFFE, 32'h3, lat);
    check("mult_latency", 64'(lat), 64'd33);
    check("mult_hilo", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFFA);

    run_op(0, 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("multu_hilo", {hi32, lo32}, 64'hFFFF_FFFE_0000_0001);

    mt(0, 4'd8, 32'h0, 1'b0);
    mt(0, 4'd9, 32'h5, 1'b0);
    run_op(0, 4'd4, 32'h3, 32'h4, lat);
    check("msub_hilo", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFF9);

    // {1, FFFFFFFF} + 2^32
    mt(0, 4'd8, 32'h1, 1'b0);
    mt(0, 4'd9, 32'hFFFF_FFFF, 1'b0);
    run_op(0, 4'd3, 32'h8000_0000, 32'h2, lat);
    check("maddu_hilo", {hi32, lo32}, 64'h0000_0002_FFFF_FFFF);

    run_op(0, 4'd6, 32'hFFFF_FFF9, 32'h2, lat);
    check("div_hilo", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(0, 4'd7, 32'd10, 32'd0, lat);
    check("divu0_latency", 64'(lat), 64'd1);
    check("divu0_hilo", {hi32, lo32}, 64'h0000_000A_FFFF_FFFF);

    run_op(0, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("div_min_hilo", {hi32, lo32}, 64'h0000_0000_8000_0000);

    // Cancel mid-CALC and coincident with done
    run_cancel(10, 32'h1234_5678, 32'h9ABC_DEF0);
    run_cancel(33, 32'h0000_0100, 32'h0000_0200);

    // MTHI while busy is ignored; MTHI in IDLE lands next cycle
    fork
      run_op(0, 4'd1, 32'h1111, 32'h2222, lat);
      begin
        repeat (6) @(negedge clk);
        start32 = 1'b1; op32 = 4'd8; a32 = 32'h1234;
        @(negedge clk);
        start32 = 1'b0;
      end
    join
    mt(0, 4'd8, 32'h1234, 1'b0);
    check("mthi_idle", 64'(hi32), 64'h1234);
    // Cancel in IDLE blocks MTLO
    mt(0, 4'd9, 32'hDEAD_BEEF, 1'b1);

    // Directed 8-bit corner: MIN / -1
    run_op(1, 4'd6, 32'h80, 32'hFF, lat);
    check("div8_min", 64'({hi8, lo8}), 64'h0080);

    // Random ops on both widths
    for (int i = 0; i < 60; i++) begin
      int          sel;
      logic [3:0]  op;
      logic [31:0] a, b, m;
      sel = i % 2;
      m   = (sel == 0) ? 32'hFFFF_FFFF : 32'hFF;
      op  = 4'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = (sel == 0) ? 32'h8000_0000 : 32'h80; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 3));
        default: ;
      endcase
      run_op(sel, op, a, b, lat);
      check("rand_latency", 64'(lat),
            ((op[2:1] == 2'b11) && ((b & m) == 32'h0)) ? 64'd1 : ((sel == 0) ? 64'd33 : 64'd9));
    end

    // Reset in the middle of a DIV
    @(negedge clk);
    drive(0, 1'b1, 4'd6, 32'd1000, 32'd7, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 4'd15, 32'h0, 32'h0, 1'b0);
    repeat (9) @(negedge clk);
    check("busy_before_rst", 64'(busy32), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("rst_mid_div");
    repeat (40) @(negedge clk);
    check("no_done_after_rst", 64'(done32), 64'd0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
